sync_fifo16: RTL and testbench
==============================

// Module: sync_fifo16
// PURPOSE
//  Single-clock synchronous FIFO with 2**BUF_WIDTH entries (16 by default) and registered read data.
//  Status outputs: empty, full, almost-empty, almost-full and an occupancy count.
//  Intended as a generic buffering stage between producer and consumer blocks in the same clock domain.
//  Must be fully synthesizable. The gate-level netlist must match RTL cycle-for-cycle on every output.
// PARAMETERS
//  BUF_WIDTH   4  address width; DEPTH = 2**BUF_WIDTH entries
//  DATA_WIDTH  4  width of each stored word
// PORTS
//  clk           in   1             single clock; all state updates on posedge
//  rst           in   1             reset, synchronous, active-high
//  buf_in        in   DATA_WIDTH    write data, sampled on posedge when wr_en=1
//  wr_en         in   1             push request
//  rd_en         in   1             pop request
//  buf_out       out  DATA_WIDTH    registered read data
//  buf_empty     out  1             fifo_counter == 0
//  buf_full      out  1             fifo_counter == DEPTH
//  almost_empty  out  1             fifo_counter <= 1
//  almost_full   out  1             fifo_counter >= DEPTH-1
//  fifo_counter  out  BUF_WIDTH+1   number of stored words, 0..DEPTH
// BEHAVIOUR
//  - Reset (rst=1 at posedge) sets:
//    - wr_ptr=0, rd_ptr=0, fifo_counter=0, buf_out=0
//    - hence buf_empty=1, almost_empty=1, buf_full=0, almost_full=0
//    - Memory contents are not cleared. Reset during any traffic discards all data.
//  - Effective operations:
//    - do_wr = wr_en & (!buf_full | rd_en)
//    - do_rd = rd_en & !buf_empty
//  - do_wr: mem[wr_ptr] <= buf_in; wr_ptr <= wr_ptr+1.
//  - do_rd: buf_out <= mem[rd_ptr]; rd_ptr <= rd_ptr+1.
//    - Data is valid right after the same posedge (1-cycle latency).
//  - buf_out holds its previous value whenever do_rd=0.
//  - Pointers are BUF_WIDTH bits wide and wrap DEPTH-1 -> 0 naturally.
//  - Counter update: +1 if do_wr&!do_rd, -1 if do_rd&!do_wr, otherwise unchanged.
//  - Simultaneous rd_en & wr_en:
//    - Neither empty nor full: both operations occur; count unchanged.
//    - Empty: write only; buf_out unchanged; count becomes 1.
//    - Full: read and write both occur; count stays DEPTH.
//  - Write while full without a read is dropped: no pointer or count change.
//  - Read while empty is ignored.
//  - All status flags are combinational decodes of fifo_counter, so they change right after the clock edge.
//  - Use no initial blocks and no delays in RTL.
// CONFIGURATION
//  FIFO16_ERR_FLAGS_EN defined:
//    - Adds outputs overflow and underflow (1 bit each), both registered, 0 on reset.
//    - overflow: 1-cycle pulse after a dropped write (wr_en & buf_full & !rd_en).
//    - underflow: 1-cycle pulse after an ignored read (rd_en & buf_empty & !wr_en).
//  FIFO16_ERR_FLAGS_EN undefined:
//    - Neither port exists; behaviour is otherwise identical.
// TESTING
//  Run RTL and synthesized netlist in lockstep with identical stimulus, 10 ns clock.
//  Compare every output every cycle; any mismatch is a failure.
//  1 rst high 15 ns, then release -> counter=0, empty=1, almost_empty=1, full=0, buf_out=0.
//  2 push 1; then push 2 and pop in the same cycle:
//    - pop returns 1, counter stays 1
//    - push 10,2..13 -> counter=14, almost_full=0
//  3 push 14 -> counter 15, almost_full=1; push 15 -> full=1, counter=16
//    - push while full -> ignored; counter 16; overflow pulses if FIFO16_ERR_FLAGS_EN
//  4 at full, push+pop same cycle -> oldest word out, count 16; then data order verified across pointer wrap
//  5 pop until empty:
//    - values appear in FIFO order
//    - almost_empty=1 at count 1; empty=1 at 0
//    - further pop ignored, buf_out holds last value
//  6 push 5, pop -> buf_out=5; assert rst mid-stream -> all outputs return to reset values next edge

Source files
------------

// File: rtl/sync_fifo16.sv
// Single-clock FIFO with 2**BUF_WIDTH entries, registered read data and occupancy flags.
// Define FIFO16_ERR_FLAGS_EN to add registered overflow/underflow pulse outputs.
module sync_fifo16 #(
    parameter int unsigned BUF_WIDTH  = 4,
    parameter int unsigned DATA_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] buf_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] buf_out,
    output logic                  buf_empty,
    output logic                  buf_full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [BUF_WIDTH:0]    fifo_counter
`ifdef FIFO16_ERR_FLAGS_EN
    ,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam int unsigned       DEPTH           = 1 << BUF_WIDTH;
    localparam logic [BUF_WIDTH:0] FULL_CNT        = {1'b1, {BUF_WIDTH{1'b0}}};
    localparam logic [BUF_WIDTH:0] ALMOST_FULL_CNT = {1'b0, {BUF_WIDTH{1'b1}}};
    localparam logic [BUF_WIDTH:0] ONE_CNT         = (BUF_WIDTH+1)'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [BUF_WIDTH-1:0]  wr_ptr;
    logic [BUF_WIDTH-1:0]  rd_ptr;
    logic                  do_wr;
    logic                  do_rd;

    always_comb begin
        buf_empty    = (fifo_counter == '0);
        buf_full     = (fifo_counter == FULL_CNT);
        almost_empty = (fifo_counter <= ONE_CNT);
        almost_full  = (fifo_counter >= ALMOST_FULL_CNT);
        // A write into a full FIFO is allowed when a read frees a slot in the same cycle.
        do_wr        = wr_en & (~buf_full | rd_en);
        do_rd        = rd_en & ~buf_empty;
    end

    // Storage has no reset; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= buf_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            buf_out      <= '0;
            fifo_counter <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + BUF_WIDTH'(1);
            end
            if (do_rd) begin
                buf_out <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + BUF_WIDTH'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   fifo_counter <= fifo_counter + ONE_CNT;
                2'b01:   fifo_counter <= fifo_counter - ONE_CNT;
                default: fifo_counter <= fifo_counter;
            endcase
        end
    end

`ifdef FIFO16_ERR_FLAGS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= wr_en & buf_full & ~rd_en;
            underflow <= rd_en & buf_empty & ~wr_en;
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo16.sv
// Self-checking bench for sync_fifo16: vector table with hand-derived count/data, a data
// scoreboard queue, a randomized traffic phase and a mid-stream reset sequence.
module tb_sync_fifo16;

    localparam int DW    = 4;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk;
    logic          rst;
    logic [DW-1:0] buf_in;
    logic          wr_en;
    logic          rd_en;
    logic [DW-1:0] buf_out;
    logic          buf_empty;
    logic          buf_full;
    logic          almost_empty;
    logic          almost_full;
    logic [AW:0]   fifo_counter;
`ifdef FIFO16_ERR_FLAGS_EN
    logic          overflow;
    logic          underflow;
`endif

    sync_fifo16 #(.BUF_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .buf_in       (buf_in),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .buf_out      (buf_out),
        .buf_empty    (buf_empty),
        .buf_full     (buf_full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .fifo_counter (fifo_counter)
`ifdef FIFO16_ERR_FLAGS_EN
        ,
        .overflow     (overflow),
        .underflow    (underflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit      wr;
        bit      rd;
        int      din;
        int      exp_cnt;
        int      exp_out;
    } vec_t;

    vec_t tbl[$];
    int   sbq[$];
    int   mcnt;
    int   mout;
    int   checks;
    int   errors;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void add(input bit w, input bit r, input int d, input int c, input int o);
        vec_t v;
        v.wr = w; v.rd = r; v.din = d; v.exp_cnt = c; v.exp_out = o;
        tbl.push_back(v);
    endfunction

    task automatic check_status(input string tag);
        chk({tag, " cnt"},    int'(fifo_counter), mcnt);
        chk({tag, " out"},    int'(buf_out),      mout);
        chk({tag, " empty"},  int'(buf_empty),    int'(mcnt == 0));
        chk({tag, " full"},   int'(buf_full),     int'(mcnt == DEPTH));
        chk({tag, " aempty"}, int'(almost_empty), int'(mcnt <= 1));
        chk({tag, " afull"},  int'(almost_full),  int'(mcnt >= DEPTH - 1));
    endtask

    // One clock of traffic; the scoreboard predicts which word a read must return.
    task automatic step(input bit w, input bit r, input int d, input string tag);
        bit full_b, empty_b, dw, dr;
        full_b  = (mcnt == DEPTH);
        empty_b = (mcnt == 0);
        dw = w && (!full_b || r);
        dr = r && !empty_b;
        wr_en  = w;
        rd_en  = r;
        buf_in = DW'(d);
        if (dr) mout = sbq.pop_front();
        if (dw) sbq.push_back(d & 15);
        mcnt = sbq.size();
        @(posedge clk);
        #1;
        check_status(tag);
`ifdef FIFO16_ERR_FLAGS_EN
        chk({tag, " ovf"}, int'(overflow),  int'(w && full_b && !r));
        chk({tag, " udf"}, int'(underflow), int'(r && empty_b && !w));
`endif
    endtask

    initial begin
        #1ms;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0; errors = 0;
        mcnt = 0; mout = 0;
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; buf_in = '0;

        add(1, 0, 1, 1, 0);
        add(1, 1, 2, 1, 1);
        for (int v = 3; v <= 15; v++) add(1, 0, v, v - 1, 1);
        add(1, 0, 0, 15, 1);
        add(1, 0, 1, 16, 1);
        add(1, 0, 9, 16, 1);                 // dropped: full, no read
        add(1, 1, 7, 16, 2);                 // full: oldest out, new word in
        for (int v = 3; v <= 15; v++) add(0, 1, 0, 18 - v, v);
        add(0, 1, 0, 2, 0);
        add(0, 1, 0, 1, 1);
        add(0, 1, 0, 0, 7);
        add(0, 1, 0, 0, 7);                  // read while empty ignored
        add(1, 1, 4, 1, 7);                  // empty: write only
        add(0, 1, 0, 0, 4);
        add(1, 0, 5, 1, 4);
        add(0, 1, 0, 0, 5);

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_status("reset");
`ifdef FIFO16_ERR_FLAGS_EN
        chk("reset ovf", int'(overflow), 0);
        chk("reset udf", int'(underflow), 0);
`endif

        foreach (tbl[i]) begin
            step(tbl[i].wr, tbl[i].rd, tbl[i].din, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d tbl_cnt", i), int'(fifo_counter), tbl[i].exp_cnt);
            chk($sformatf("vec%0d tbl_out", i), int'(buf_out), tbl[i].exp_out);
        end

        for (int i = 0; i < 400; i++) begin
            bit w, r;
            w = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 70 : 30));
            r = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 30 : 70));
            step(w, r, int'($urandom_range(0, 15)), $sformatf("rnd%0d", i));
        end

        // Mid-stream reset discards stored data and restores reset values.
        step(1, 0, 6, "pre_rst_a");
        step(1, 0, 8, "pre_rst_b");
        rst = 1'b1; wr_en = 1'b1; rd_en = 1'b1; buf_in = 4'd3;
        @(posedge clk);
        #1;
        sbq.delete(); mcnt = 0; mout = 0;
        check_status("midrst");
        rst = 1'b0;
        step(0, 1, 0, "post_rst_pop");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
